// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants, counter type and helpers for regfile_sb.
package regfile_pkg;
  localparam int unsigned REG_ZERO = 0;
  localparam int PEND_W_MAX = 8;
  typedef logic [PEND_W_MAX-1:0] cnt_t;
  function automatic int max_cnt(input int pend_w);
    return (1 << pend_w) - 1;
  endfunction
endpackage

// File: rtl/sb_counter.sv
// sb_counter: saturating outstanding-write counter for one register.
// REGFILE_BYPASS_EN adds multi_o (more than one write outstanding).
module sb_counter
  import regfile_pkg::*;
#(
  parameter int PEND_W = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc_i,
  input  logic dec_i,
  input  logic clr_i,
  output logic pend_o,
  output logic full_o
`ifdef REGFILE_BYPASS_EN
  ,
  output logic multi_o
`endif
);
  localparam cnt_t MAX = cnt_t'(max_cnt(PEND_W));
  cnt_t cnt_q, cnt_d;
  logic up;
  assign up = inc_i && !full_o;
  assign pend_o = cnt_q != '0;
  assign full_o = cnt_q == MAX;
`ifdef REGFILE_BYPASS_EN
  assign multi_o = cnt_q > cnt_t'(1);
`endif
  // simultaneous accepted issue and writeback cancel out
  always_comb
    cnt_d = clr_i ? '0 :
            (up && !dec_i) ? cnt_q + cnt_t'(1) :
            (dec_i && !up && pend_o) ? cnt_q - cnt_t'(1) : cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  always @(posedge clk)
    if (rst_n && !clr_i && dec_i && !up)
      assert (pend_o) else $error("sb_counter: writeback with no outstanding write");
endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: 2R/1W register file with per-register write scoreboard.
// Define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int BUS_SIZE = 32,
  parameter int DIR_SIZE_INTERNAL = 5,
  parameter int MEM_SIZE = 32,
  parameter int PEND_W = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [DIR_SIZE_INTERNAL-1:0] dirA,
  input  logic [DIR_SIZE_INTERNAL-1:0] dirB,
  output logic [BUS_SIZE-1:0]          outA,
  output logic [BUS_SIZE-1:0]          outB,
  output logic                         pendA,
  output logic                         pendB,
  input  logic                         issueEn,
  input  logic [DIR_SIZE_INTERNAL-1:0] issueDir,
  output logic                         issueReady,
  input  logic                         enWrite,
  input  logic [DIR_SIZE_INTERNAL-1:0] dirWrite,
  input  logic [BUS_SIZE-1:0]          writeData,
  input  logic                         flush,
  output logic                         anyPend
);
  localparam int N = 2 ** DIR_SIZE_INTERNAL;
  // full address space is allocated so register 0 and out-of-range slots read as constant 0
  logic [BUS_SIZE-1:0] mem_q [N];
  logic [N-1:0] pend, full;
  logic wr_ok;
`ifdef REGFILE_BYPASS_EN
  logic [N-1:0] multi;
`endif
  function automatic logic in_range(input logic [DIR_SIZE_INTERNAL-1:0] a);
    return a != DIR_SIZE_INTERNAL'(REG_ZERO) && 32'(a) < MEM_SIZE;
  endfunction
  assign wr_ok = enWrite && in_range(dirWrite);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) for (int i = 0; i < N; i++) mem_q[i] <= '0;
    else if (wr_ok) mem_q[dirWrite] <= writeData;
  for (genvar g = 0; g < N; g++) begin : g_cnt
    if (g > 0 && g < MEM_SIZE) begin : g_on
      sb_counter #(.PEND_W(PEND_W)) u_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc_i  (issueEn && issueDir == DIR_SIZE_INTERNAL'(g)),
        .dec_i  (wr_ok && dirWrite == DIR_SIZE_INTERNAL'(g)),
        .clr_i  (flush),
        .pend_o (pend[g]),
        .full_o (full[g])
`ifdef REGFILE_BYPASS_EN
        ,
        .multi_o(multi[g])
`endif
      );
    end else begin : g_off
      assign pend[g] = 1'b0;
      assign full[g] = 1'b0;
`ifdef REGFILE_BYPASS_EN
      assign multi[g] = 1'b0;
`endif
    end
  end
  assign issueReady = !full[issueDir];
  assign anyPend = |pend;
`ifdef REGFILE_BYPASS_EN
  logic hit_a, hit_b;
  assign hit_a = wr_ok && dirWrite == dirA;
  assign hit_b = wr_ok && dirWrite == dirB;
  assign outA = hit_a ? writeData : mem_q[dirA];
  assign outB = hit_b ? writeData : mem_q[dirB];
  assign pendA = hit_a ? multi[dirA] : pend[dirA];
  assign pendB = hit_b ? multi[dirB] : pend[dirB];
`else
  assign outA = mem_q[dirA];
  assign outB = mem_q[dirB];
  assign pendA = pend[dirA];
  assign pendB = pend[dirB];
`endif
endmodule
